// File: rtl/sw_cond_pkg.sv
// sw_cond_pkg: shared defaults for the slide-switch input conditioner.
// Rev 1.0
`default_nettype none

package sw_cond_pkg;

  localparam int DEFAULT_WIDTH           = 10;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
  localparam int SIM_DEBOUNCE_CYCLES     = 8;

  // Counter width that can hold DEBOUNCE_CYCLES-1 without wrapping.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_input_conditioner_debounce_bit.sv
// debounce_bit: one switch bit -- synchroniser chain, stability counter, clean level and edge pulses.
// Rev 1.0
`default_nettype none

module debounce_bit
  import sw_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall,
  output logic accept
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sw_sync;
  logic [CNT_W-1:0]       cnt;

  assign sw_sync = sync_q[SYNC_STAGES-1];
  // Exposed so the top can register sw_changed in the same cycle as the pulses.
  assign accept  = (sw_sync != sw_clean) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt      <= '0;
      sw_clean <= 1'b0;
      sw_rise  <= 1'b0;
      sw_fall  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
      if (sw_sync == sw_clean || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
      if (accept) begin
        sw_clean <= sw_sync;
      end
      sw_rise <= accept & sw_sync;
      sw_fall <= accept & ~sw_sync;
    end
  end

endmodule

`default_nettype wire

// File: rtl/switch_input_conditioner.sv
// switch_input_conditioner: per-bit sync + debounce of slide switches feeding the PIO in_port.
// Rev 1.0
`default_nettype none

module switch_input_conditioner
  import sw_cond_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .sw_raw  (sw_raw[i]),
      .sw_clean(sw_clean[i]),
      .sw_rise (sw_rise[i]),
      .sw_fall (sw_fall[i]),
      .accept  (accept[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= |accept;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_switch_input_conditioner.sv
// tb_switch_input_conditioner: directed + random stimulus, scoreboard against a sliding-window debounce model.
// Rev 1.0
`default_nettype none

module tb_switch_input_conditioner;
  import sw_cond_pkg::*;

  localparam int W  = 10;
  localparam int SS = 2;
  localparam int DB = SIM_DEBOUNCE_CYCLES;

  typedef struct packed {
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;
  } obs_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_clean, sw_rise, sw_fall;
  logic         sw_changed;

  int checks = 0;
  int errors = 0;

  obs_t         expq[$];
  logic [W-1:0] dly[$];
  logic [W-1:0] win[$];
  logic [W-1:0] m_clean = '0;

  switch_input_conditioner #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_raw    (sw_raw),
    .sw_clean  (sw_clean),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // A bit flips when the last DB synchronised samples all disagree with its clean level.
  task automatic model_edge(input logic [W-1:0] raw, input logic rn);
    obs_t         e;
    logic [W-1:0] s, acc, tmp;
    if (!rn) begin
      dly = {};
      for (int k = 0; k < SS; k++) dly.push_back('0);
      win = {};
      m_clean = '0;
      e = '0;
    end else begin
      s = dly.pop_front();
      dly.push_back(raw);
      win.push_back(s);
      if (win.size() > DB) tmp = win.pop_front();
      acc = '0;
      if (win.size() == DB) begin
        for (int b = 0; b < W; b++) begin
          acc[b] = 1'b1;
          foreach (win[k]) if (win[k][b] == m_clean[b]) acc[b] = 1'b0;
        end
      end
      e.rise    = acc & ~m_clean;
      e.fall    = acc & m_clean;
      e.changed = |acc;
      m_clean   = m_clean ^ acc;
      e.clean   = m_clean;
    end
    expq.push_back(e);
  endtask

  task automatic step(input logic [W-1:0] raw);
    sw_raw = raw;
    @(posedge clk);
    model_edge(raw, reset_n);
    @(negedge clk);
  endtask

  task automatic hold(input logic [W-1:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw);
  endtask

  // Asynchronous assert away from any edge, checked immediately, then held over a few edges.
  task automatic pulse_reset(input logic [W-1:0] raw, input int n);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_clean", sw_clean, '0);
    check("async_reset_rise", sw_rise, '0);
    check("async_reset_fall", sw_fall, '0);
    check("async_reset_changed", W'(sw_changed), '0);
    hold(raw, n);
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("sw_clean", sw_clean, e.clean);
      check("sw_rise", sw_rise, e.rise);
      check("sw_fall", sw_fall, e.fall);
      check("sw_changed", W'(sw_changed), W'(e.changed));
    end
  end

  initial begin
    logic [W-1:0] cur;
    int           hold_cnt[W];
    for (int k = 0; k < SS; k++) dly.push_back('0);
    @(negedge clk);

    // Power-up with all switches high, then release.
    hold(10'h3FF, 3);
    reset_n = 1'b1;
    hold(10'h3FF, 14);

    // Clean step on bit 3 from all-low.
    hold(10'h000, 14);
    hold(10'h008, 14);

    // 7-cycle glitch rejected, 9-cycle pulse accepted.
    hold(10'h009, 7);
    hold(10'h008, 14);
    hold(10'h009, 9);
    hold(10'h008, 24);

    // Bit 5 bounces every 3 cycles, then settles high.
    cur = 10'h008;
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 0) cur[5] = ~cur[5];
      step(cur);
    end
    hold(10'h028, 14);

    // Simultaneous rise on bits 1,9 and fall on bit 4.
    hold(10'h010, 14);
    hold(10'h202, 14);

    // Bit 2 pending when reset hits; accepted after release.
    hold(10'h000, 14);
    hold(10'h004, 5);
    pulse_reset(10'h004, 2);
    hold(10'h004, 14);

    // Random bouncing with mixed hold lengths and occasional resets.
    cur = sw_raw;
    foreach (hold_cnt[b]) hold_cnt[b] = int'($urandom_range(1, 14));
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < W; b++) begin
        hold_cnt[b]--;
        if (hold_cnt[b] <= 0) begin
          cur[b] = ~cur[b];
          hold_cnt[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 30))
                                                     : int'($urandom_range(1, 12));
        end
      end
      if ($urandom_range(0, 299) == 0) pulse_reset(cur, int'($urandom_range(1, 3)));
      step(cur);
    end
    hold(cur, 14);

    @(negedge clk);
    check("scoreboard_drain", W'(expq.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
